// File: rtl/or8_frame_accum.sv
// Frame accumulator: ORs FRAME_LEN bytes into one result held until the sink accepts it.
// Optional saturation early-out is selected with `define OR8_ACC_EARLY_EN.
module or8_frame_accum #(
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic [7:0] out_count,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [7:0] FrameLen = 8'(FRAME_LEN);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] or_f;
  logic [7:0] cnt_inc;
  logic       in_xfer;
  logic       last_idle;
  logic       last_accum;

  // OR8 datapath: A = accumulator, B = incoming byte.
  for (genvar i = 0; i < 8; i++) begin : g_or8
    assign or_f[i] = acc_q[i] | in_data[i];
  end

  assign cnt_inc = cnt_q + 8'd1;
  assign in_xfer = in_valid & in_ready;

`ifdef OR8_ACC_EARLY_EN
  // A saturated accumulator cannot change, so the frame closes early.
  assign last_idle  = (FrameLen == 8'd1) || (in_data == 8'hFF);
  assign last_accum = (cnt_inc == FrameLen) || (or_f == 8'hFF);
`else
  assign last_idle  = (FrameLen == 8'd1);
  assign last_accum = (cnt_inc == FrameLen);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          state_d = last_idle ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (in_xfer && last_accum) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != StDone);
    out_valid = (state_q == StDone);
    busy      = (state_q == StAccum);
    out_data  = (state_q == StDone) ? acc_q : 8'h00;
    out_count = (state_q == StDone) ? cnt_q : 8'h00;
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          acc_d = in_data;
          cnt_d = 8'd1;
        end
      end
      StAccum: begin
        if (in_xfer) begin
          acc_d = or_f;
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        if (out_ready) begin
          acc_d = 8'h00;
          cnt_d = 8'h00;
        end
      end
      default: begin
        acc_d = 8'h00;
        cnt_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 8'h00;
      cnt_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_or8_frame_accum.sv
// Scoreboard bench for or8_frame_accum; two instances (FRAME_LEN 4 and 1) share the inputs.
module tb_or8_frame_accum;

`ifdef OR8_ACC_EARLY_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready4, out_valid4, busy4;
  logic [7:0] out_data4, out_count4;
  logic       in_ready1, out_valid1, busy1;
  logic [7:0] out_data1, out_count1;

  always #5 clk = ~clk;

  or8_frame_accum #(.FRAME_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .out_data(out_data4), .out_count(out_count4), .out_valid(out_valid4),
    .out_ready(out_ready), .busy(busy4)
  );

  or8_frame_accum #(.FRAME_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_count(out_count1), .out_valid(out_valid1),
    .out_ready(out_ready), .busy(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  stim_q[$];  // {valid, data}; a valid=0 entry is a one-cycle bubble
  bit          rdy_q[$];   // out_ready per cycle, 1 once exhausted
  logic [15:0] sb_q[$];    // expected {data, count}
  logic [15:0] obs_q[$];   // observed {data, count} at each output handshake

  logic [7:0] m_acc;
  logic [7:0] m_cnt;
  int valid_cycles, unstable, rdy_err, lat_last;

  task automatic model_byte(input int fl, input logic [7:0] d);
    m_acc = (m_cnt == 8'd0) ? d : (m_acc | d);
    m_cnt = m_cnt + 8'd1;
    if (m_cnt == 8'(fl) || (EarlyEn && m_acc == 8'hFF)) begin
      sb_q.push_back({m_acc, m_cnt});
      m_acc = 8'h00;
      m_cnt = 8'h00;
    end
  endtask

  task automatic model_clear();
    m_acc = 8'h00;
    m_cnt = 8'h00;
    sb_q.delete();
  endtask

  // Drives stim_q/rdy_q into the shared inputs and records what the selected DUT produces.
  task automatic run(input bit sel, input int budget);
    int          n = 0;
    int          last_acc = 0;
    logic        pv = 1'b0;
    logic        ph = 1'b0;
    logic [15:0] pd = 16'h0;
    valid_cycles = 0;
    unstable     = 0;
    rdy_err      = 0;
    lat_last     = -1;
    obs_q.delete();
    forever begin
      logic        v, r, a, h;
      logic [15:0] od;
      @(negedge clk);
      if (stim_q.size() != 0) begin
        in_valid = stim_q[0][8];
        in_data  = stim_q[0][7:0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      out_ready = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
      #4;
      v  = sel ? out_valid1 : out_valid4;
      r  = sel ? in_ready1 : in_ready4;
      od = sel ? {out_data1, out_count1} : {out_data4, out_count4};
      a  = in_valid & r;
      h  = v & out_ready;
      if (v) valid_cycles++;
      if (v && r) rdy_err++;
      if (pv && !ph && od != pd) unstable++;
      if (v && !pv) lat_last = n - last_acc;
      if (h) obs_q.push_back(od);
      if (a) begin
        model_byte(sel ? 1 : 4, in_data);
        last_acc = n;
      end
      if (stim_q.size() != 0 && (a || !stim_q[0][8])) void'(stim_q.pop_front());
      pv = v;
      ph = h;
      pd = od;
      n++;
      if (stim_q.size() == 0 && rdy_q.size() == 0 && !a && !v) break;
      if (n >= budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL run_timeout: got %0d cycles, required fewer than %0d", n, budget);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid4, out_data4, out_count4, busy4} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {out_valid4, out_data4, out_count4, busy4});
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready4);
    end
    stim_q = '{9'h101, 9'h102};
    run(1'b0, 50);
    n_checks++;
    if (busy4 !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_busy: got %b required 1", busy4);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid4, out_data4, out_count4, busy4, in_ready4} !== 19'h1) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h required 1",
               {out_valid4, out_data4, out_count4, busy4, in_ready4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    stim_q = '{9'h110, 9'h120, 9'h140, 9'h180};
    run(1'b0, 50);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 16'hF004) begin
      n_fail++;
      $display("FAIL post_reset_frame: got %0d results first %h required 1 result F004",
               obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 16'hxxxx);
    end
    sb_q.delete();
  endtask

  task automatic test_basic();
    stim_q = '{9'h101, 9'h102, 9'h104, 9'h108};
    run(1'b0, 50);
    n_checks++;
    if (obs_q.size() != sb_q.size()) begin
      n_fail++;
      $display("FAIL basic_nres: got %0d required %0d", obs_q.size(), sb_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < sb_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== sb_q[i]) begin
        n_fail++;
        $display("FAIL basic_result%0d: got %h required %h", i, obs_q[i], sb_q[i]);
      end
    end
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0] !== 16'h0F04) begin
      n_fail++;
      $display("FAIL basic_const: got %h required 0F04", (obs_q.size() != 0) ? obs_q[0] : 16'hxxxx);
    end
    n_checks++;
    if (valid_cycles != 1 || lat_last != 1) begin
      n_fail++;
      $display("FAIL basic_timing: got valid %0d lat %0d required valid 1 lat 1",
               valid_cycles, lat_last);
    end
    sb_q.delete();
  endtask

  task automatic test_backpressure();
    stim_q = '{9'h101, 9'h102, 9'h104, 9'h108, 9'h110, 9'h120, 9'h140, 9'h180};
    rdy_q  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run(1'b0, 60);
    n_checks++;
    if (obs_q.size() != sb_q.size()) begin
      n_fail++;
      $display("FAIL bp_nres: got %0d required %0d", obs_q.size(), sb_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < sb_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== sb_q[i]) begin
        n_fail++;
        $display("FAIL bp_result%0d: got %h required %h", i, obs_q[i], sb_q[i]);
      end
    end
    n_checks++;
    if (valid_cycles != 7 || unstable != 0 || rdy_err != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got valid %0d unstable %0d in_ready_hi %0d required 7 0 0",
               valid_cycles, unstable, rdy_err);
    end
    sb_q.delete();
  endtask

  task automatic test_bubbles();
    stim_q = '{9'h180, 9'h000, 9'h000, 9'h101, 9'h000, 9'h140, 9'h120};
    run(1'b0, 50);
    n_checks++;
    if (obs_q.size() != 1 || sb_q.size() != 1 || obs_q[0] !== sb_q[0] || obs_q[0] !== 16'hE104) begin
      n_fail++;
      $display("FAIL bubbles: got %0d results first %h required 1 result E104",
               obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 16'hxxxx);
    end
    sb_q.delete();
  endtask

  task automatic test_early();
    stim_q = '{9'h1F0, 9'h10F, 9'h133, 9'h144, 9'h108, 9'h180, 9'h101, 9'h102};
    run(1'b0, 60);
    n_checks++;
    if (obs_q.size() != sb_q.size()) begin
      n_fail++;
      $display("FAIL early_nres: got %0d required %0d", obs_q.size(), sb_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < sb_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== sb_q[i]) begin
        n_fail++;
        $display("FAIL early_result%0d: got %h required %h", i, obs_q[i], sb_q[i]);
      end
    end
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0] !== (EarlyEn ? 16'hFF02 : 16'hFF04)) begin
      n_fail++;
      $display("FAIL early_first: got %h required %h",
               (obs_q.size() != 0) ? obs_q[0] : 16'hxxxx, EarlyEn ? 16'hFF02 : 16'hFF04);
    end
    sb_q.delete();
  endtask

  task automatic test_len1();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    stim_q = '{9'h1A5, 9'h15A};
    run(1'b1, 50);
    n_checks++;
    if (obs_q.size() != sb_q.size()) begin
      n_fail++;
      $display("FAIL len1_nres: got %0d required %0d", obs_q.size(), sb_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < sb_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== sb_q[i]) begin
        n_fail++;
        $display("FAIL len1_result%0d: got %h required %h", i, obs_q[i], sb_q[i]);
      end
    end
    n_checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 16'hA501 || obs_q[1] !== 16'h5A01 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL len1_const: got %0d results busy %b required A501 5A01 busy 0",
               obs_q.size(), busy1);
    end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_early();
    test_len1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
